idwt: RTL and testbench



---
 rtl/idwt_pkg.sv | 48 ++++
 rtl/idwt_ctrl.sv | 56 +++++
 rtl/idwt_fadd.sv | 73 +++++++
 rtl/idwt_fmul.sv | 50 +++++
 rtl/idwt.sv | 125 ++++++++++++
 tb/tb_idwt.sv | 193 +++++++++++++++++++
 6 files changed

// File: rtl/idwt_pkg.sv
// Shared constants, state encoding and helpers for the inverse D4 lifting
// reconstruction (idwt) and its fp32 arithmetic cells.
package idwt_pkg;
    localparam int FP32_W = 32;

    localparam logic [FP32_W-1:0] IKA     = 32'h3F0483EE;
    localparam logic [FP32_W-1:0] IKD     = 32'h3FF746EA;
    localparam logic [FP32_W-1:0] C1      = 32'h3EDDB3D7;
    localparam logic [FP32_W-1:0] C2      = 32'hBD8930A3;
    localparam logic [FP32_W-1:0] C3      = 32'h3FDDB3D7;
    localparam logic [FP32_W-1:0] FP_QNAN = 32'h7FC00000;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_SA   = 4'd1;
    localparam logic [3:0] S_DD   = 4'd2;
    localparam logic [3:0] S_D1   = 4'd3;
    localparam logic [3:0] S_E1   = 4'd4;
    localparam logic [3:0] S_E2   = 4'd5;
    localparam logic [3:0] S_E3   = 4'd6;
    localparam logic [3:0] S_E4   = 4'd7;
    localparam logic [3:0] S_O1   = 4'd8;
    localparam logic [3:0] S_O2   = 4'd9;
    localparam logic [3:0] S_OUT  = 4'd10;

    typedef enum logic [3:0] {
        IDLE = S_IDLE, SA = S_SA, DD = S_DD, D1 = S_D1, E1 = S_E1, E2 = S_E2,
        E3 = S_E3, E4 = S_E4, O1 = S_O1, O2 = S_O2, OUT = S_OUT
    } state_t;

    // One load enable per datapath register, decoded from the state.
    typedef struct packed {
        logic ld_in;
        logic s1;
        logic t;
        logic d1;
        logic p;
        logic q;
        logic r;
        logic xe;
        logic m;
        logic xo;
        logic hist;
    } en_t;

    function automatic logic [FP32_W-1:0] fneg(input logic [FP32_W-1:0] x);
        return {~x[FP32_W-1], x[FP32_W-2:0]};
    endfunction
endpackage

// File: rtl/idwt_ctrl.sv
// Sequencer for idwt: walks the nine arithmetic steps, owns both handshakes
// and decodes the per-state register load enables.
module idwt_ctrl
    import idwt_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    input  logic   out_ready,
    output logic   in_ready,
    output logic   out_valid,
    output state_t state,
    output en_t    en
);
    state_t state_reg, state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        en         = '0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    en.ld_in   = 1'b1;
                    state_next = SA;
                end
            end
            SA: begin en.s1 = 1'b1; state_next = DD;  end
            DD: begin en.t  = 1'b1; state_next = D1;  end
            D1: begin en.d1 = 1'b1; state_next = E1;  end
            E1: begin en.p  = 1'b1; state_next = E2;  end
            E2: begin en.q  = 1'b1; state_next = E3;  end
            E3: begin en.r  = 1'b1; state_next = E4;  end
            E4: begin en.xe = 1'b1; state_next = O1;  end
            O1: begin en.m  = 1'b1; state_next = O2;  end
            O2: begin en.xo = 1'b1; state_next = OUT; end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    en.hist    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign state = state_reg;
endmodule

// File: rtl/idwt_fadd.sv
// Combinational fp32 adder: round-to-nearest-even, denormals flushed to zero.
module idwt_fadd
    import idwt_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic [FP32_W-1:0] y
);
    logic        a_nan, b_nan, a_inf, b_inf, a_z, b_z, swap, sgn, g, st;
    logic [7:0]  e_big, e_sml, dexp;
    logic [4:0]  dsh;
    logic [23:0] m_big, m_sml, mt;
    logic [49:0] shifted;
    logic [26:0] a27, b27, n;
    logic [27:0] s;
    logic [24:0] mr;
    int          e, lz;

    always_comb begin
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == '0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == '0);
        a_z   = (a[30:23] == 8'h00);
        b_z   = (b[30:23] == 8'h00);
        swap  = b[30:0] > a[30:0];
        e_big = swap ? b[30:23] : a[30:23];
        e_sml = swap ? a[30:23] : b[30:23];
        m_big = {1'b1, swap ? b[22:0] : a[22:0]};
        m_sml = {1'b1, swap ? a[22:0] : b[22:0]};
        sgn   = swap ? b[31] : a[31];
        dexp  = e_big - e_sml;
        // Beyond 31 places the smaller operand lives entirely in the sticky bit.
        dsh     = (dexp > 8'd31) ? 5'd31 : dexp[4:0];
        shifted = {m_sml, 26'b0} >> dsh;
        a27     = {m_big, 3'b000};
        b27     = {shifted[49:24], |shifted[23:0]};
        s       = (a[31] == b[31]) ? ({1'b0, a27} + {1'b0, b27}) : ({1'b0, a27} - {1'b0, b27});
        e       = int'(e_big);
        lz      = 0;
        if (s[27]) begin
            n = {s[27:2], s[1] | s[0]};
            e = e + 1;
        end else begin
            for (int i = 0; i < 27; i++) begin
                if (s[i]) lz = 26 - i;
            end
            n = s[26:0] << lz;
            e = e - lz;
        end
        mt = n[26:3];
        g  = n[2];
        st = n[1] | n[0];
        mr = {1'b0, mt} + {24'b0, g & (st | mt[0])};
        if (mr[24]) begin
            mt = mr[24:1];
            e  = e + 1;
        end else begin
            mt = mr[23:0];
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) y = FP_QNAN;
        else if (a_inf)          y = a;
        else if (b_inf)          y = b;
        else if (a_z && b_z)     y = {a[31] & b[31], 31'b0};
        else if (b_z)            y = a;
        else if (a_z)            y = b;
        else if (s == '0)        y = '0;
        else if (e >= 255)       y = {sgn, 8'hFF, 23'b0};
        else if (e <= 0)         y = {sgn, 31'b0};
        else                     y = {sgn, e[7:0], mt[22:0]};
    end
endmodule

// File: rtl/idwt_fmul.sv
// Combinational fp32 multiplier: round-to-nearest-even, denormals flushed to zero.
module idwt_fmul
    import idwt_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic [FP32_W-1:0] y
);
    logic        a_nan, b_nan, a_inf, b_inf, a_z, b_z, sg, g, st;
    logic [47:0] prod;
    logic [23:0] mt;
    logic [24:0] mr;
    int          e;

    always_comb begin
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == '0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == '0);
        a_z   = (a[30:23] == 8'h00);
        b_z   = (b[30:23] == 8'h00);
        sg    = a[31] ^ b[31];
        prod  = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e     = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (prod[47]) begin
            mt = prod[47:24];
            g  = prod[23];
            st = |prod[22:0];
            e  = e + 1;
        end else begin
            mt = prod[46:23];
            g  = prod[22];
            st = |prod[21:0];
        end
        mr = {1'b0, mt} + {24'b0, g & (st | mt[0])};
        if (mr[24]) begin
            mt = mr[24:1];
            e  = e + 1;
        end else begin
            mt = mr[23:0];
        end

        if (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) y = FP_QNAN;
        else if (a_inf || b_inf)                                y = {sg, 8'hFF, 23'b0};
        else if (a_z || b_z)                                    y = {sg, 31'b0};
        else if (e >= 255)                                      y = {sg, 8'hFF, 23'b0};
        else if (e <= 0)                                        y = {sg, 31'b0};
        else                                                    y = {sg, e[7:0], mt[22:0]};
    end
endmodule

// File: rtl/idwt.sv
// Inverse D4 lifting step on one shared fp32 multiplier and adder.
// Optional IDWT_ERR_EN: replaces Inf/NaN inputs by +0 and raises sticky err.
module idwt
    import idwt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_first,
    input  logic [FP32_W-1:0] an_in,
    input  logic [FP32_W-1:0] dn_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP32_W-1:0] x_even,
    output logic [FP32_W-1:0] x_odd
`ifdef IDWT_ERR_EN
    ,
    output logic              err
`endif
);
    state_t state;
    en_t    en;

    logic              first_reg;
    logic [FP32_W-1:0] a_reg, d_reg, s1_reg, t_reg, d1_reg, p_reg, q_reg, r_reg;
    logic [FP32_W-1:0] xe_reg, m_reg, xo_reg, s1p_reg, d1p_reg;
    logic [FP32_W-1:0] a_san, d_san, s1p_eff, d1p_eff;
    logic [FP32_W-1:0] mul_a, mul_b, mul_y, add_a, add_b, add_y;

    idwt_ctrl u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .state    (state),
        .en       (en)
    );

    idwt_fmul u_mul (.a(mul_a), .b(mul_b), .y(mul_y));
    idwt_fadd u_add (.a(add_a), .b(add_b), .y(add_y));

`ifdef IDWT_ERR_EN
    logic bad_a, bad_d, err_reg;
    assign bad_a = (an_in[30:23] == 8'hFF);
    assign bad_d = (dn_in[30:23] == 8'hFF);
    assign a_san = bad_a ? '0 : an_in;
    assign d_san = bad_d ? '0 : dn_in;
    assign err   = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            err_reg <= 1'b0;
        else if (en.ld_in && (bad_a || bad_d)) err_reg <= 1'b1;
    end
`else
    assign a_san = an_in;
    assign d_san = dn_in;
`endif

    // A frame start sees zero history for this pair only.
    assign s1p_eff = first_reg ? '0 : s1p_reg;
    assign d1p_eff = first_reg ? '0 : d1p_reg;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        add_a = '0;
        add_b = '0;
        case (state)
            SA: begin mul_a = a_reg;  mul_b = IKA;           end
            DD: begin mul_a = d_reg;  mul_b = IKD;           end
            D1: begin add_a = t_reg;  add_b = fneg(s1p_eff); end
            E1: begin mul_a = C1;     mul_b = d1_reg;        end
            E2: begin mul_a = C2;     mul_b = d1p_eff;       end
            E3: begin add_a = p_reg;  add_b = q_reg;         end
            E4: begin add_a = s1_reg; add_b = fneg(r_reg);   end
            O1: begin mul_a = C3;     mul_b = xe_reg;        end
            O2: begin add_a = d1_reg; add_b = m_reg;         end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_reg <= 1'b0;
            a_reg     <= '0;
            d_reg     <= '0;
            s1_reg    <= '0;
            t_reg     <= '0;
            d1_reg    <= '0;
            p_reg     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            xe_reg    <= '0;
            m_reg     <= '0;
            xo_reg    <= '0;
            s1p_reg   <= '0;
            d1p_reg   <= '0;
        end else begin
            if (en.ld_in) begin
                a_reg     <= a_san;
                d_reg     <= d_san;
                first_reg <= in_first;
            end
            if (en.s1) s1_reg <= mul_y;
            if (en.t)  t_reg  <= mul_y;
            if (en.d1) d1_reg <= add_y;
            if (en.p)  p_reg  <= mul_y;
            if (en.q)  q_reg  <= mul_y;
            if (en.r)  r_reg  <= add_y;
            if (en.xe) xe_reg <= add_y;
            if (en.m)  m_reg  <= mul_y;
            if (en.xo) xo_reg <= add_y;
            if (en.hist) begin
                s1p_reg <= s1_reg;
                d1p_reg <= d1_reg;
            end
        end
    end

    assign x_even = xe_reg;
    assign x_odd  = xo_reg;
endmodule

// File: tb/tb_idwt.sv
// Directed bench for idwt: reset, reconstruction with and without history,
// output backpressure, mid-pair reset and non-finite input handling.
module tb_idwt;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_first, out_valid, out_ready;
    logic [31:0] an_in, dn_in, x_even, x_odd;
`ifdef IDWT_ERR_EN
    logic        err;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    idwt dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_first (in_first),
        .an_in    (an_in),
        .dn_in    (dn_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_even   (x_even),
        .x_odd    (x_odd)
`ifdef IDWT_ERR_EN
        ,
        .err      (err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) begin
            passes++;
            $display("check %s: %h", tag, obs);
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Same sign and at most one unit in the last place apart.
    task automatic chk_ulp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        logic [31:0] diff;
        diff = (obs > expv) ? obs - expv : expv - obs;
        checks++;
        assert (((obs[31] === expv[31]) && (diff <= 32'd1)) === 1'b1) begin
            passes++;
            $display("check %s: %h", tag, obs);
        end else begin
            $error("FAIL %s: observed %h expected %h +-1ulp", tag, obs, expv);
        end
    endtask

    task automatic chk_nan(input string tag, input logic [31:0] obs);
        checks++;
        assert (((obs[30:23] === 8'hFF) && (obs[22:0] !== 23'd0)) === 1'b1) begin
            passes++;
            $display("check %s: %h", tag, obs);
        end else begin
            $error("FAIL %s: observed %h expected a NaN", tag, obs);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic first);
        in_valid = 1'b1;
        an_in    = a;
        dn_in    = d;
        in_first = first;
        for (int i = 0; i < 30 && !in_ready; i++) tick();
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // The accept edge counts as edge 1, so out_valid is up after edge 10.
    task automatic run_pair(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic first, input logic [31:0] ee, input logic [31:0] eo);
        send(a, d, first);
        repeat (8) tick();
        chk({tag, "_lat_lo"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({tag, "_lat_hi"}, {31'd0, out_valid}, 32'd1);
        chk_ulp({tag, "_even"}, x_even, ee);
        chk_ulp({tag, "_odd"}, x_odd, eo);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, {out_valid, in_ready}, 32'd1);
    endtask

    logic [31:0] hold_e, hold_o;
    logic        ok;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        out_ready = 1'b0;
        an_in     = '0;
        dn_in     = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_x_even", x_even, 32'h0);
        chk("rst_x_odd", x_odd, 32'h0);
`ifdef IDWT_ERR_EN
        chk("rst_err", {31'd0, err}, 32'd0);
`endif

        // a=1, d=0, new frame: xe = IKA, xo = sqrt3*IKA.
        run_pair("first", 32'h3F800000, 32'h0, 1'b1, 32'h3F0483EE, 32'h3F6585F8);
        // a=0, d=0 with s1p=IKA: xe = C1*IKA, xo = IKA*(3/4 - 1).
        run_pair("hist", 32'h0, 32'h0, 1'b0, 32'h3E6585F8, 32'hBE0483EE);

        // Backpressure: 20 cycles of out_ready=0 while a new pair is offered.
        send(32'h3F800000, 32'h0, 1'b1);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        hold_e   = x_even;
        hold_o   = x_odd;
        in_valid = 1'b1;
        an_in    = 32'h40000000;
        dn_in    = 32'h3F800000;
        in_first = 1'b0;
        ok       = 1'b1;
        repeat (20) begin
            tick();
            if (x_even !== hold_e || x_odd !== hold_o || out_valid !== 1'b1 || in_ready !== 1'b0)
                ok = 1'b0;
        end
        chk("bp_stable", {31'd0, ok}, 32'd1);
        chk_ulp("bp_even", x_even, 32'h3F0483EE);
        chk_ulp("bp_odd", x_odd, 32'h3F6585F8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", {out_valid, in_ready}, 32'd1);
        run_pair("after_bp", 32'h0, 32'h0, 1'b0, 32'h3E6585F8, 32'hBE0483EE);

        // Reset while the pair is in E2 (four edges after accept).
        send(32'h0, 32'h0, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        ok  = 1'b1;
        repeat (12) begin
            tick();
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        chk("rst_mid_quiet", {31'd0, ok}, 32'd1);
        run_pair("post_rst", 32'h3F800000, 32'h0, 1'b0, 32'h3F0483EE, 32'h3F6585F8);

        // NaN detail coefficient.
`ifdef IDWT_ERR_EN
        chk("err_clear", {31'd0, err}, 32'd0);
        run_pair("nan_zeroed", 32'h0, 32'h7FC00000, 1'b1, 32'h0, 32'h0);
        chk("err_set", {31'd0, err}, 32'd1);
        run_pair("err_next", 32'h3F800000, 32'h0, 1'b1, 32'h3F0483EE, 32'h3F6585F8);
        chk("err_sticky", {31'd0, err}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("err_rst", {31'd0, err}, 32'd0);
`else
        send(32'h0, 32'h7FC00000, 1'b1);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        chk("nan_valid", {31'd0, out_valid}, 32'd1);
        chk_nan("nan_even", x_even);
        chk_nan("nan_odd", x_odd);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
